radix2_dif_ibfly: RTL and testbench

- Pipelined radix-2 decimation-in-frequency butterfly for the inverse-FFT path. It is the reverse-direction counterpart of the forward DIT butterfly.
- Each beat performs add/subtract first, then multiplies the difference by the twiddle. The twiddle is conjugated in inverse mode.
- Optional 1/2 scaling is applied per stage.
- Sits between IFFT stage buffers. A valid/ready handshake on both sides allows chaining stages with backpressure.

---
 rtl/radix2_dif_ibfly.sv | 157 +++++++++++++++
 tb/tb_radix2_dif_ibfly.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_dif_ibfly.sv
// Pipelined radix-2 DIF butterfly for the inverse-FFT path.
// Ports: valid/ready handshake on both sides, a/b samples and a Q2.14 twiddle in; a+b and (a-b)*W' out.
module radix2_dif_ibfly #(
  parameter int bit_width = 16,
  parameter int TW_FRAC   = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        inverse,
  input  logic                        scale,
  input  logic signed [bit_width-1:0] Re_i1,
  input  logic signed [bit_width-1:0] Im_i1,
  input  logic signed [bit_width-1:0] Re_i2,
  input  logic signed [bit_width-1:0] Im_i2,
  input  logic signed [15:0]          sin_data,
  input  logic signed [15:0]          cos_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [bit_width-1:0] Re_o1,
  output logic signed [bit_width-1:0] Im_o1,
  output logic signed [bit_width-1:0] Re_o2,
  output logic signed [bit_width-1:0] Im_o2
);

  localparam int SW = bit_width + 1;
  localparam int PW = bit_width + 18;

  localparam logic signed [PW-1:0] MAXV =
    (PW'(1) <<< (bit_width - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW_FRAC - 1);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic signed [bit_width-1:0] sat(
    input logic signed [PW-1:0] x
  );
    if (x > MAXV) return MAXV[bit_width-1:0];
    if (x < MINV) return MINV[bit_width-1:0];
    return x[bit_width-1:0];
  endfunction

  function automatic logic signed [PW-1:0] rnd(
    input logic signed [PW-1:0] x
  );
    return (x + RND) >>> TW_FRAC;
  endfunction

  // S1: add/sub with optional floor halving
  logic signed [SW-1:0] add_r, add_i, sub_r, sub_i;

  always_comb begin
    add_r = SW'(Re_i1) + SW'(Re_i2);
    add_i = SW'(Im_i1) + SW'(Im_i2);
    sub_r = SW'(Re_i1) - SW'(Re_i2);
    sub_i = SW'(Im_i1) - SW'(Im_i2);
    if (scale) begin
      add_r = add_r >>> 1;
      add_i = add_i >>> 1;
      sub_r = sub_r >>> 1;
      sub_i = sub_i >>> 1;
    end
  end

  logic                 v1, inv1;
  logic signed [SW-1:0] s_r1, s_i1, d_r1, d_i1;
  logic signed [15:0]   c1, sn1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      inv1 <= 1'b0;
      s_r1 <= '0;
      s_i1 <= '0;
      d_r1 <= '0;
      d_i1 <= '0;
      c1   <= '0;
      sn1  <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        inv1 <= inverse;
        s_r1 <= add_r;
        s_i1 <= add_i;
        d_r1 <= sub_r;
        d_i1 <= sub_i;
        c1   <= cos_data;
        sn1  <= sin_data;
      end
    end
  end

  // S2: complex multiply, sin negated in inverse mode
  logic signed [PW-1:0] m_rc, m_is, m_rs, m_ic;
  logic signed [PW-1:0] p_re, p_im;

  always_comb begin
    m_rc = PW'(d_r1) * PW'(c1);
    m_is = PW'(d_i1) * PW'(sn1);
    m_rs = PW'(d_r1) * PW'(sn1);
    m_ic = PW'(d_i1) * PW'(c1);
    if (inv1) begin
      p_re = m_rc + m_is;
      p_im = m_ic - m_rs;
    end else begin
      p_re = m_rc - m_is;
      p_im = m_rs + m_ic;
    end
  end

  logic                 v2;
  logic signed [PW-1:0] p_re2, p_im2;
  logic signed [SW-1:0] s_r2, s_i2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      p_re2 <= '0;
      p_im2 <= '0;
      s_r2  <= '0;
      s_i2  <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        p_re2 <= p_re;
        p_im2 <= p_im;
        s_r2  <= s_r1;
        s_i2  <= s_i1;
      end
    end
  end

  // S3: round half up, saturate, register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Re_o1     <= '0;
      Im_o1     <= '0;
      Re_o2     <= '0;
      Im_o2     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        Re_o1 <= sat(PW'(s_r2));
        Im_o1 <= sat(PW'(s_i2));
        Re_o2 <= sat(rnd(p_re2));
        Im_o2 <= sat(rnd(p_im2));
      end
    end
  end

endmodule

// File: tb/tb_radix2_dif_ibfly.sv
// Self-checking bench for radix2_dif_ibfly.
// Table vectors, random burst with backpressure, mid-stream reset.
module tb_radix2_dif_ibfly;

  typedef struct {
    logic signed [15:0] ar, ai, br, bi, c, s;
    logic               inv, scl;
    logic signed [15:0] o1r, o1i, o2r, o2i;
  } vec_t;

  typedef struct {
    logic signed [15:0] r1, i1, r2, i2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, inverse, scale;
  logic out_valid, out_ready;
  logic signed [15:0] Re_i1, Im_i1, Re_i2, Im_i2;
  logic signed [15:0] sin_data, cos_data;
  logic signed [15:0] Re_o1, Im_o1, Re_o2, Im_o2;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   bp0    = 0;
  logic bp_on  = 1'b0;
  logic held   = 1'b0;
  logic saw_stall = 1'b0;
  exp_t hd;
  exp_t sb[$];
  vec_t tbl[13];

  radix2_dif_ibfly dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .scale(scale),
    .Re_i1(Re_i1), .Im_i1(Im_i1),
    .Re_i2(Re_i2), .Im_i2(Im_i2),
    .sin_data(sin_data), .cos_data(cos_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .Re_o1(Re_o1), .Im_o1(Im_o1),
    .Re_o2(Re_o2), .Im_o2(Im_o2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if (x < 0 && (x % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    longint sr, si, dr, di, c, s, re, im;
    sr = longint'(v.ar) + longint'(v.br);
    si = longint'(v.ai) + longint'(v.bi);
    dr = longint'(v.ar) - longint'(v.br);
    di = longint'(v.ai) - longint'(v.bi);
    if (v.scl) begin
      sr = fdiv(sr, 2);
      si = fdiv(si, 2);
      dr = fdiv(dr, 2);
      di = fdiv(di, 2);
    end
    c = longint'(v.c);
    s = longint'(v.s);
    if (v.inv) begin
      re = dr * c + di * s;
      im = di * c - dr * s;
    end else begin
      re = dr * c - di * s;
      im = dr * s + di * c;
    end
    e.r1 = 16'(clip(sr));
    e.i1 = 16'(clip(si));
    e.r2 = 16'(clip(fdiv(re + 8192, 16384)));
    e.i2 = 16'(clip(fdiv(im + 8192, 16384)));
    return e;
  endfunction

  function automatic vec_t mk(
    input logic signed [15:0] ar, ai, br, bi, c, s,
    input logic inv, scl,
    input logic signed [15:0] o1r, o1i, o2r, o2i
  );
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
    v.c = c; v.s = s; v.inv = inv; v.scl = scl;
    v.o1r = o1r; v.o1i = o1i; v.o2r = o2r; v.o2i = o2i;
    return v;
  endfunction

  function automatic exp_t tbl_exp(input vec_t v);
    exp_t e;
    e.r1 = v.o1r; e.i1 = v.o1i;
    e.r2 = v.o2r; e.i2 = v.o2i;
    return e;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.ar = 16'($urandom); v.ai = 16'($urandom);
    v.br = 16'($urandom); v.bi = 16'($urandom);
    v.c = 16'($urandom); v.s = 16'($urandom);
    v.inv = 1'($urandom); v.scl = 1'($urandom);
    v.o1r = '0; v.o1i = '0; v.o2r = '0; v.o2i = '0;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = !(bp_on && (cyc - bp0) >= 5 && (cyc - bp0) <= 8);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_re1", Re_o1, hd.r1);
        chk("hold_im2", Im_o2, hd.i2);
      end
      held = out_valid && !out_ready;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        saw_stall = 1'b1;
        hd.r1 = Re_o1; hd.i1 = Im_o1;
        hd.r2 = Re_o2; hd.i2 = Im_o2;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("re1", Re_o1, e.r1);
          chk("im1", Im_o1, e.i1);
          chk("re2", Re_o2, e.r2);
          chk("im2", Im_o2, e.i2);
        end
      end
    end
  end

  task automatic send(input vec_t v, input exp_t e);
    Re_i1 = v.ar; Im_i1 = v.ai;
    Re_i2 = v.br; Im_i2 = v.bi;
    cos_data = v.c; sin_data = v.s;
    inverse = v.inv; scale = v.scl;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #2;
        return;
      end
      @(posedge clk);
      #2;
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    tbl[0]  = mk(1000, 0, 200, 0, 16'h4000, 0, 0, 0,
                 1200, 0, 800, 0);
    tbl[1]  = mk(0, 0, -1000, 0, 0, 16'h4000, 0, 0,
                 -1000, 0, 0, 1000);
    tbl[2]  = mk(0, 0, -1000, 0, 0, 16'h4000, 1, 0,
                 -1000, 0, 0, -1000);
    tbl[3]  = mk(32767, -32768, 32767, -32768, 16'h4000, 0, 0, 0,
                 32767, -32768, 0, 0);
    tbl[4]  = mk(32767, -32768, 32767, -32768, 16'h4000, 0, 0, 1,
                 32767, -32768, 0, 0);
    tbl[5]  = mk(3, 0, 0, 0, 16'h2000, 0, 0, 0, 3, 0, 2, 0);
    tbl[6]  = mk(1, 0, 0, 0, 16'h2000, 0, 0, 0, 1, 0, 1, 0);
    tbl[7]  = mk(-3, 0, 0, 0, 16'h2000, 0, 0, 0, -3, 0, -1, 0);
    tbl[8]  = mk(-3, 0, 0, 0, 16'h4000, 0, 0, 1, -2, 0, -2, 0);
    tbl[9]  = mk(100, -50, 30, 20, 16'h4000, 0, 1, 0,
                 130, -30, 70, -70);
    tbl[10] = mk(1000, 0, 0, 0, 16'h8000, 0, 0, 0,
                 1000, 0, -2000, 0);
    tbl[11] = mk(30000, 0, -30000, 0, 16'h8000, 16'h8000, 0, 0,
                 0, 0, -32768, -32768);
    tbl[12] = mk(30000, 0, -30000, 0, 16'h8000, 16'h8000, 1, 0,
                 0, 0, -32768, 32767);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inverse = 1'b0; scale = 1'b0;
    Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0;
    sin_data = '0; cos_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_re1", Re_o1, 0);
    chk("rst_im2", Im_o2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < 13; i++) send(tbl[i], tbl_exp(tbl[i]));
    in_valid = 1'b0;
    drain();

    @(posedge clk);
    #2;
    bp0 = cyc;
    bp_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v = rnd_vec();
      send(v, model(v));
    end
    in_valid = 1'b0;
    drain();
    bp_on = 1'b0;
    chk("stall_seen", saw_stall, 1);

    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = rnd_vec();
      send(v, model(v));
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_re1", Re_o1, 0);
    chk("mid_rst_im1", Im_o1, 0);
    chk("mid_rst_re2", Re_o2, 0);
    chk("mid_rst_im2", Im_o2, 0);
    chk("mid_rst_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    send(tbl[9], tbl_exp(tbl[9]));
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", out_valid, 0);
    @(negedge clk);
    chk("lat_c2", out_valid, 0);
    @(negedge clk);
    chk("lat_c3", out_valid, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
